g15_photo_reader_emu: RTL and testbench
=======================================

Name: g15_photo_reader_emu

Overview:
- Emulates the built-in photoelectric tape reader on the far end of connector PL6.
- Takes the motor relay commands (PHOTO_TAPE_FWD/REV) from the G-15 and plays back a host-loaded tape image on the five photocell lines at reader frame timing.
- Drives the relay-energized status (WAIT_FOR_TAPE).
- Sits beside g15_top in the board wrapper; its outputs feed PL6_1..7 and PL6_18.

Parameters:
- DEPTH, 1024, tape image capacity in frames; power of two.
- START_MS, 10, motor spin-up delay in ms before the first frame.
- HOLD_MS, 2, ms a frame's holes are presented.
- GAP_MS, 2, ms of all-dark between frames.

Ports:
- CLOCK  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_ms  in  1  one-CLOCK pulse every 1 ms.
- tape_fwd  in  1  PHOTO_TAPE_FWD (relay RY-A).
- tape_rev  in  1  PHOTO_TAPE_REV (relay RY-B).
- host_clear  in  1  pulse: empty the tape image.
- host_data  in  5  frame to append; bit0 = channel 1.
- host_valid  in  1  host_data valid.
- host_ready  out  1  append accepted when valid&ready.
- PHOTO1..PHOTO5  out  1 each  photocell outputs; 1 = hole.
- wait_for_tape  out  1  relay energized (to PL6_18).
- tape_end  out  1  forward run-out: pos == len.
- tape_leader  out  1  reverse at leader: pos == 0.
- tape_pos  out  log2(DEPTH)+1  current tape position.
- tape_len  out  log2(DEPTH)+1  frames loaded.

Behaviour:
- Interface: one clock (CLOCK); reset is synchronous and active-high (rst).
- Reset: state=IDLE; pos=0; len=0; PHOTO*=0; wait_for_tape=0; tape_end=0; tape_leader=1; host_ready=0 in the reset cycle, then per rule.
- Image storage: synchronous RAM, DEPTH x 5.
- Loading:
  - host_ready = (state==IDLE) & ~host_clear & (len < DEPTH).
  - On accept: img[len] <= host_data; len++.
  - host_clear (IDLE only, ignored otherwise): len=0, pos=0.
  - Loading never moves pos.
- Command decode: cmd_f = tape_fwd & ~tape_rev; cmd_r = tape_rev & ~tape_fwd; both or neither means stop.
- wait_for_tape = registered (tape_fwd | tape_rev): one-cycle latency, independent of state.
- States: IDLE, SPIN, HOLD, GAP, RUNOUT. ms counter cnt counts tick_ms pulses.
- IDLE:
  - PHOTO*=0.
  - cmd_f or cmd_r: latch dir, cnt=0, go to SPIN.
- SPIN:
  - After START_MS ticks, enter HOLD if a frame is available: forward needs pos<len; reverse needs pos>0. Otherwise enter RUNOUT.
  - Frame presented: forward img[pos]; reverse img[pos-1].
  - PHOTO* valid from the cycle the state becomes HOLD; RAM read is issued one cycle earlier.
- HOLD:
  - After HOLD_MS ticks: PHOTO*=0; pos++ (fwd) or pos-- (rev); go to GAP.
- GAP:
  - After GAP_MS ticks, apply the same availability check as SPIN: go to HOLD or RUNOUT.
- RUNOUT:
  - PHOTO*=0; motor keeps running.
  - Stays until the command changes.
- Command change: in any non-IDLE state, if the command drops, reverses, or both relays are set, go to IDLE within one cycle.
  - PHOTO*=0.
  - pos unchanged; an aborted HOLD does not advance pos.
  - A new command restarts at SPIN, so spin-up applies again.
- Flags:
  - tape_end = (pos==len) & (len!=0).
  - tape_leader = (pos==0).
  - Both are registered and follow pos/len with one cycle of latency.
- Counters: pos is never decremented below 0 or incremented beyond len.
- Tick boundary: a tick_ms coincident with a state transition counts toward the new state's duration only if it arrives after the transition cycle.
- Reset mid-frame: immediate return to reset values, image contents are lost logically (len=0).

Test Plan:
- Params DEPTH=16, START_MS=3, HOLD_MS=2, GAP_MS=2. Load 0x1F, 0x0A, 0x15; assert tape_fwd -> PHOTO=0x1F after 3 ticks, held 2 ticks, dark 2 ticks, then 0x0A, then 0x15, then RUNOUT. Expect tape_end=1, tape_pos=3, wait_for_tape=1 throughout.
- From pos=3, assert tape_rev -> frames 0x15, 0x0A, 0x1F in that order, then tape_leader=1, pos=0, PHOTO=0.
- Drop tape_fwd one tick into the HOLD of frame 0x0A (pos=1) -> IDLE next cycle, PHOTO=0, pos stays 1. Re-assert -> 3-tick spin-up, then 0x0A again.
- tape_fwd=tape_rev=1 -> no frames, state IDLE, wait_for_tape=1 one cycle later.
- Load 16 frames -> host_ready=0 at len=16. Assert host_valid during a forward run -> no write, len unchanged. host_clear while IDLE -> len=0, pos=0, tape_leader=1.
- Assert rst during HOLD -> next cycle PHOTO=0, state IDLE, len=0, wait_for_tape=0.

Source files
------------

// File: rtl/g15_photo_reader_emu.sv
// ---------------------------------------------------------------------------
// g15_photo_reader_emu
//
// Stands in for the G-15 photoelectric tape reader on connector PL6. The host
// loads a tape image frame by frame. The G-15 motor relays (FWD/REV) then play
// that image back on the five photocell lines, using reader frame timing in
// milliseconds: spin-up, then hole/dark alternation.
//
// Ports
//   CLOCK          system clock
//   rst            synchronous active-high reset
//   tick_ms        one-CLOCK pulse per millisecond
//   tape_fwd       PHOTO_TAPE_FWD relay (RY-A)
//   tape_rev       PHOTO_TAPE_REV relay (RY-B)
//   host_clear     pulse: empty the tape image (honoured only while IDLE)
//   host_data      frame to append, bit0 = channel 1
//   host_valid     host_data valid
//   host_ready     append accepted when host_valid & host_ready
//   PHOTO1..5      photocell outputs, 1 = hole
//   wait_for_tape  relay energized (to PL6_18), registered
//   tape_end       forward run-out flag: pos == len, len != 0 (registered)
//   tape_leader    reverse leader flag: pos == 0 (registered)
//   tape_pos       current tape position
//   tape_len       number of frames loaded
// ---------------------------------------------------------------------------
module g15_photo_reader_emu #(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned START_MS = 10,
    parameter int unsigned HOLD_MS  = 2,
    parameter int unsigned GAP_MS   = 2
) (
    input  logic                       CLOCK,
    input  logic                       rst,
    input  logic                       tick_ms,
    input  logic                       tape_fwd,
    input  logic                       tape_rev,
    input  logic                       host_clear,
    input  logic [4:0]                 host_data,
    input  logic                       host_valid,
    output logic                       host_ready,
    output logic                       PHOTO1,
    output logic                       PHOTO2,
    output logic                       PHOTO3,
    output logic                       PHOTO4,
    output logic                       PHOTO5,
    output logic                       wait_for_tape,
    output logic                       tape_end,
    output logic                       tape_leader,
    output logic [$clog2(DEPTH):0]     tape_pos,
    output logic [$clog2(DEPTH):0]     tape_len
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SPIN   = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_RUNOUT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          dir_q, dir_d;        // 1 = forward, 0 = reverse
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [PW-1:0] len_q, len_d;
    logic          wait_q;
    logic          end_q;
    logic          leader_q;

    logic [4:0]    img [DEPTH];
    logic [4:0]    rd_q;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    logic          cmd_f, cmd_r, cmd_ok, avail;
    logic [4:0]    photo;

    assign cmd_f  = tape_fwd & ~tape_rev;
    assign cmd_r  = tape_rev & ~tape_fwd;
    // The running direction must still be commanded; a drop, a reversal or
    // both relays set all count as a change.
    assign cmd_ok = dir_q ? cmd_f : cmd_r;
    assign avail  = dir_q ? (pos_q < len_q) : (pos_q != '0);

    assign host_ready = ~rst & (state_q == S_IDLE) & ~host_clear
                        & (len_q < PW'(DEPTH));

    // Reverse presents the frame behind the head. The low-bit subtraction
    // wraps correctly even at pos == DEPTH.
    assign rd_addr = dir_q ? pos_q[AW-1:0] : (pos_q[AW-1:0] - AW'(1));
    assign wr_addr = len_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        len_d   = len_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;

        if (state_q == S_IDLE) begin
            if (host_clear) begin
                len_d = '0;
                pos_d = '0;
            end else if (host_valid && host_ready) begin
                wr_en = 1'b1;
                len_d = len_q + PW'(1);
            end
            if (cmd_f || cmd_r) begin
                dir_d   = cmd_f;
                cnt_d   = '0;
                state_d = S_SPIN;
            end
        end else if (!cmd_ok) begin
            // Abort has priority over a completing HOLD, so pos stays put.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_SPIN, S_GAP: begin
                    if (tick_ms) begin
                        if (cnt_q == ((state_q == S_SPIN) ? 16'(START_MS - 1)
                                                          : 16'(GAP_MS - 1))) begin
                            cnt_d = '0;
                            if (avail) begin
                                // RAM read issued here so data is ready on HOLD entry.
                                rd_en   = 1'b1;
                                state_d = S_HOLD;
                            end else begin
                                state_d = S_RUNOUT;
                            end
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (tick_ms) begin
                        if (cnt_q == 16'(HOLD_MS - 1)) begin
                            cnt_d   = '0;
                            pos_d   = dir_q ? (pos_q + PW'(1)) : (pos_q - PW'(1));
                            state_d = S_GAP;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                default: ;  // RUNOUT: motor runs, nothing presented
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            pos_q    <= '0;
            len_q    <= '0;
            wait_q   <= 1'b0;
            end_q    <= 1'b0;
            leader_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            len_q    <= len_d;
            wait_q   <= tape_fwd | tape_rev;
            end_q    <= (pos_q == len_q) && (len_q != '0);
            leader_q <= (pos_q == '0);
        end
    end

    // Image RAM: contents are not reset; len = 0 makes them unreachable.
    always_ff @(posedge CLOCK) begin
        if (wr_en) begin
            img[wr_addr] <= host_data;
        end
        if (rd_en) begin
            rd_q <= img[rd_addr];
        end
    end

    assign photo         = (state_q == S_HOLD) ? rd_q : 5'd0;
    assign PHOTO1        = photo[0];
    assign PHOTO2        = photo[1];
    assign PHOTO3        = photo[2];
    assign PHOTO4        = photo[3];
    assign PHOTO5        = photo[4];
    assign wait_for_tape = wait_q;
    assign tape_end      = end_q;
    assign tape_leader   = leader_q;
    assign tape_pos      = pos_q;
    assign tape_len      = len_q;

endmodule

// File: tb/tb_g15_photo_reader_emu.sv
module tb_g15_photo_reader_emu;

    logic       CLOCK = 1'b0;
    logic       rst = 1'b1;
    logic       tick_ms = 1'b0;
    logic       tape_fwd = 1'b0;
    logic       tape_rev = 1'b0;
    logic       host_clear = 1'b0;
    logic [4:0] host_data = '0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       PHOTO1, PHOTO2, PHOTO3, PHOTO4, PHOTO5;
    logic       wait_for_tape, tape_end, tape_leader;
    logic [4:0] tape_pos, tape_len;
    logic [4:0] photo;

    int checks = 0;
    int errors = 0;

    assign photo = {PHOTO5, PHOTO4, PHOTO3, PHOTO2, PHOTO1};

    always #5 CLOCK = ~CLOCK;

    g15_photo_reader_emu #(
        .DEPTH(16), .START_MS(3), .HOLD_MS(2), .GAP_MS(2)
    ) dut (
        .CLOCK(CLOCK), .rst(rst), .tick_ms(tick_ms),
        .tape_fwd(tape_fwd), .tape_rev(tape_rev),
        .host_clear(host_clear), .host_data(host_data),
        .host_valid(host_valid), .host_ready(host_ready),
        .PHOTO1(PHOTO1), .PHOTO2(PHOTO2), .PHOTO3(PHOTO3),
        .PHOTO4(PHOTO4), .PHOTO5(PHOTO5),
        .wait_for_tape(wait_for_tape), .tape_end(tape_end),
        .tape_leader(tape_leader), .tape_pos(tape_pos), .tape_len(tape_len)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(negedge CLOCK);
    endtask

    task automatic tick();
        tick_ms = 1'b1;
        @(negedge CLOCK);
        tick_ms = 1'b0;
        @(negedge CLOCK);
    endtask

    task automatic load(input logic [4:0] d);
        host_data  = d;
        host_valid = 1'b1;
        cyc();
        host_valid = 1'b0;
    endtask

    // lead ticks of dark (spin or gap), then a frame held for two ticks.
    task automatic frame(input string tag, input int lead, input logic [4:0] exp,
                         input logic [4:0] pos_after);
        for (int i = 0; i < lead - 1; i++) tick();
        chk({tag, "_dark"}, 8'(photo), 8'h00);
        tick();
        chk({tag, "_on"}, 8'(photo), 8'(exp));
        tick();
        chk({tag, "_held"}, 8'(photo), 8'(exp));
        chk({tag, "_wait"}, 8'(wait_for_tape), 8'h01);
        tick();
        chk({tag, "_off"}, 8'(photo), 8'h00);
        chk({tag, "_pos"}, 8'(tape_pos), 8'(pos_after));
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_photo", 8'(photo), 8'h00);
        chk("rst_len", 8'(tape_len), 8'h00);
        chk("rst_pos", 8'(tape_pos), 8'h00);
        chk("rst_leader", 8'(tape_leader), 8'h01);
        chk("rst_end", 8'(tape_end), 8'h00);
        chk("rst_wait", 8'(wait_for_tape), 8'h00);
        chk("rst_ready", 8'(host_ready), 8'h00);
        rst = 1'b0;
        cyc();
        chk("ready_after_rst", 8'(host_ready), 8'h01);

        // Load three frames, play forward
        load(5'h1F); load(5'h0A); load(5'h15);
        chk("len3", 8'(tape_len), 8'h03);
        chk("pos_unmoved", 8'(tape_pos), 8'h00);
        tape_fwd = 1'b1;
        cyc();
        chk("fwd_wait", 8'(wait_for_tape), 8'h01);
        frame("f0", 3, 5'h1F, 5'd1);
        frame("f1", 2, 5'h0A, 5'd2);
        frame("f2", 2, 5'h15, 5'd3);
        tick(); tick();
        chk("runout_photo", 8'(photo), 8'h00);
        chk("runout_end", 8'(tape_end), 8'h01);
        chk("runout_pos", 8'(tape_pos), 8'h03);
        chk("runout_wait", 8'(wait_for_tape), 8'h01);
        tick(); tick();
        chk("runout_stays", 8'(photo), 8'h00);

        // Reverse from pos 3: change -> IDLE, then SPIN
        tape_fwd = 1'b0; tape_rev = 1'b1;
        cyc(); cyc();
        frame("r0", 3, 5'h15, 5'd2);
        frame("r1", 2, 5'h0A, 5'd1);
        frame("r2", 2, 5'h1F, 5'd0);
        tick(); tick();
        chk("leader_flag", 8'(tape_leader), 8'h01);
        chk("leader_pos", 8'(tape_pos), 8'h00);
        chk("leader_photo", 8'(photo), 8'h00);
        chk("leader_end", 8'(tape_end), 8'h00);

        // Abort one tick into HOLD of frame 0x0A
        tape_rev = 1'b0;
        cyc();
        tape_fwd = 1'b1;
        cyc();
        frame("a0", 3, 5'h1F, 5'd1);
        tick();
        tick();
        chk("a1_on", 8'(photo), 8'h0A);
        tick();
        chk("a1_mid", 8'(photo), 8'h0A);
        tape_fwd = 1'b0;
        cyc();
        chk("abort_photo", 8'(photo), 8'h00);
        chk("abort_pos", 8'(tape_pos), 8'h01);
        chk("abort_idle", 8'(host_ready), 8'h01);
        tape_fwd = 1'b1;
        cyc();
        frame("a2", 3, 5'h0A, 5'd2);
        tape_fwd = 1'b0;
        cyc();
        chk("wait_drop", 8'(wait_for_tape), 8'h00);

        // Both relays: stop
        tape_fwd = 1'b1; tape_rev = 1'b1;
        cyc();
        chk("both_wait", 8'(wait_for_tape), 8'h01);
        for (int i = 0; i < 5; i++) tick();
        chk("both_photo", 8'(photo), 8'h00);
        chk("both_pos", 8'(tape_pos), 8'h02);
        chk("both_idle", 8'(host_ready), 8'h01);
        tape_fwd = 1'b0; tape_rev = 1'b0;
        cyc();

        // host_clear while IDLE
        host_clear = 1'b1;
        #1;
        chk("clear_ready", 8'(host_ready), 8'h00);
        cyc();
        host_clear = 1'b0;
        chk("clear_len", 8'(tape_len), 8'h00);
        chk("clear_pos", 8'(tape_pos), 8'h00);
        cyc();
        chk("clear_leader", 8'(tape_leader), 8'h01);

        // Host writes refused during a run
        tape_fwd = 1'b1;
        cyc();
        host_data = 5'h07; host_valid = 1'b1;
        #1;
        chk("run_ready", 8'(host_ready), 8'h00);
        cyc(); cyc();
        chk("run_nowrite", 8'(tape_len), 8'h00);
        host_valid = 1'b0;
        tick(); tick(); tick();
        chk("empty_runout", 8'(photo), 8'h00);
        tape_fwd = 1'b0;
        cyc();

        // Fill to capacity
        for (int i = 0; i < 16; i++) load(5'(i + 1));
        #1;
        chk("full_len", 8'(tape_len), 8'h10);
        chk("full_ready", 8'(host_ready), 8'h00);
        load(5'h1F);
        chk("full_nowrite", 8'(tape_len), 8'h10);

        // Reset during HOLD
        tape_fwd = 1'b1;
        cyc();
        tick(); tick(); tick();
        chk("pre_rst_photo", 8'(photo), 8'h01);
        tick();
        rst = 1'b1;
        cyc();
        chk("mid_rst_photo", 8'(photo), 8'h00);
        chk("mid_rst_len", 8'(tape_len), 8'h00);
        chk("mid_rst_wait", 8'(wait_for_tape), 8'h00);
        chk("mid_rst_leader", 8'(tape_leader), 8'h01);
        chk("mid_rst_ready", 8'(host_ready), 8'h00);
        rst = 1'b0; tape_fwd = 1'b0;
        cyc();
        chk("post_rst_idle", 8'(host_ready), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
